mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one main-memory block port between the instruction cache and the data cache of the RV32IM pipeline. Both caches issue block-refill or write-back requests with a busy-wait handshake. The arbiter serialises those requests onto the memory with round-robin fairness and routes returned block data back to the requester. It also flags a memory that never completes.

## Interface
- ADDR_WIDTH, 28: block address width (byte address [31:4]).
- DATA_WIDTH, 128: block width (4 words).
- TIMEOUT, 255: maximum grant cycles before abort; counter width is clog2(TIMEOUT+1).

- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- I_READ  in  1  I-cache refill request.
- I_ADDRESS  in  ADDR_WIDTH  I-cache block address.
- I_READDATA  out  DATA_WIDTH  refill data to I-cache (registered).
- I_BUSYWAIT  out  1  I-cache stall.
- D_READ, D_WRITE  in  1 each  D-cache refill / write-back request.
- D_ADDRESS  in  ADDR_WIDTH  D-cache block address.
- D_WRITEDATA  in  DATA_WIDTH  write-back block.
- D_READDATA  out  DATA_WIDTH  refill data to D-cache (registered).
- D_BUSYWAIT  out  1  D-cache stall.
- M_READ, M_WRITE  out  1 each  memory strobes (registered).
- M_ADDRESS  out  ADDR_WIDTH  memory block address (registered).
- M_WRITEDATA  out  DATA_WIDTH  memory write block (registered).
- M_READDATA  in  DATA_WIDTH  memory read block.
- M_BUSYWAIT  in  1  memory busy.
- ARB_ERROR  out  1  sticky timeout flag.

## Operation
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Owner register: I or D. Last-winner register LAST: reset value I, so D wins the first tie.
- D request = D_READ | D_WRITE. If both D strobes are high, the request is a write (M_WRITE=1, M_READ=0).
- IDLE: if only one request is active, grant that requester. If both are active, grant the requester that is not LAST. On the grant edge, load M_ADDRESS and M_WRITEDATA (D only), set the matching strobe, clear the grant counter and set LAST.
- GRANT_x: hold strobe, address and data. Increment the grant counter each cycle, saturating at TIMEOUT.
  - Completion edge: counter ≥1 and M_BUSYWAIT=0. On a read, latch M_READDATA into x's READDATA register. Drop the strobes and go to RELEASE.
  - Timeout edge: counter = TIMEOUT with M_BUSYWAIT still high. Set ARB_ERROR, drop the strobes, go to RELEASE, and leave READDATA unchanged.
- RELEASE: lasts one cycle, then IDLE. The owner's BUSYWAIT is low during this cycle.
- Busy-wait rule (combinational): X_BUSYWAIT = request_X & ~(state==RELEASE & owner==X). A non-requesting cache sees BUSYWAIT=0.
- Requesters must deassert at the edge that ends RELEASE. A request still high in IDLE is a new transaction.
- A D-cache write-back followed by a refill is two transactions. An I request pending at that point wins between them (round-robin).
- Requests are not sampled outside IDLE. A request that drops during GRANT does not abort the memory transaction; it completes and its data is discarded by the cache.
- ARB_ERROR is cleared only by reset.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE and LAST to I.
  - M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA, I_READDATA, D_READDATA, ARB_ERROR and the counter go to 0.
  - BUSYWAIT outputs follow the combinational rule, so an active request shows BUSYWAIT=1.

## Timing
- Request first visible in IDLE at cycle 0. GRANT begins at cycle 1 with the strobe high.
- Memory with busy latency L (M_BUSYWAIT high for cycles 1..L, low at L+1) completes at the edge ending cycle L+1. RELEASE is cycle L+2; READDATA and BUSYWAIT=0 are valid then. IDLE is cycle L+3.
- Back-to-back service: the second requester's grant begins at cycle L+4, giving 1 idle cycle between transactions.
- A memory that never raises M_BUSYWAIT completes at the first GRANT edge: request to RELEASE takes 2 cycles.
- A timeout reaches RELEASE TIMEOUT+1 cycles after the grant.

## Test plan
- Single I refill, L=4, I_ADDRESS=0x0000010, memory data 0xDEADBEEF_…_00000013:
  - M_READ is high for cycles 1–5 with M_ADDRESS=0x0000010.
  - I_BUSYWAIT is low only in cycle 6, with I_READDATA equal to the memory block.
- Simultaneous I_READ and D_READ after reset: D is granted first, then I is granted at cycle L+4. A second simultaneous pair is granted to D again (LAST=I after that pair).
- D_WRITE with D_WRITEDATA=0x11112222_33334444_55556666_77778888: M_WRITE is high with that data, M_READ stays 0, and D_READDATA is unchanged.
- With TIMEOUT=8, memory holding M_BUSYWAIT high forever: ARB_ERROR rises at the edge ending grant cycle 8, RELEASE follows, and ARB_ERROR stays high until reset.
- RESET pulled low during GRANT_D cycle 3: M_WRITE and M_READ fall immediately, all registers read 0. After release, a held D_READ is re-granted from IDLE.
- D-cache write-back then refill with I_READ pending: the order is D write, I read, D read, each separated by RELEASE + IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory port between I-cache and D-cache
module mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  M_READ,
  output logic                  M_WRITE,
  output logic [ADDR_WIDTH-1:0] M_ADDRESS,
  output logic [DATA_WIDTH-1:0] M_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] M_READDATA,
  input  logic                  M_BUSYWAIT,
  output logic                  ARB_ERROR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  state_t        state, state_next;
  logic          owner_d;
  logic          last_d;
  logic [CW-1:0] grant_cnt;
  logic [CW-1:0] cnt_inc;
  logic          d_req;
  logic          grant_i, grant_d, finish, expire;

  assign d_req = D_READ | D_WRITE;

  // cnt_inc is the number of the grant cycle now in progress (1 in the first one)
  assign cnt_inc = (grant_cnt == CW'(TIMEOUT)) ? grant_cnt : grant_cnt + CW'(1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    finish     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (I_READ && (!d_req || last_d)) begin
          grant_i    = 1'b1;
          state_next = GRANT_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (!M_BUSYWAIT) begin
          finish     = 1'b1;
          state_next = RELEASE;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          expire     = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDRESS   <= '0;
      M_WRITEDATA <= '0;
      I_READDATA  <= '0;
      D_READDATA  <= '0;
      ARB_ERROR   <= 1'b0;
      grant_cnt   <= '0;
      owner_d     <= 1'b0;
      last_d      <= 1'b0;
    end else if (grant_i) begin
      M_ADDRESS <= I_ADDRESS;
      M_READ    <= 1'b1;
      M_WRITE   <= 1'b0;
      grant_cnt <= '0;
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
    end else if (grant_d) begin
      // a write-back takes priority when both D strobes are raised
      M_ADDRESS   <= D_ADDRESS;
      M_WRITEDATA <= D_WRITEDATA;
      M_WRITE     <= D_WRITE;
      M_READ      <= ~D_WRITE;
      grant_cnt   <= '0;
      owner_d     <= 1'b1;
      last_d      <= 1'b1;
    end else if (state == GRANT_I || state == GRANT_D) begin
      grant_cnt <= cnt_inc;
      if (finish || expire) begin
        M_READ  <= 1'b0;
        M_WRITE <= 1'b0;
      end
      if (expire) ARB_ERROR <= 1'b1;
      if (finish && M_READ) begin
        if (owner_d) D_READDATA <= M_READDATA;
        else         I_READDATA <= M_READDATA;
      end
    end
  end

  assign I_BUSYWAIT = I_READ & ~(state == RELEASE && !owner_d);
  assign D_BUSYWAIT = d_req  & ~(state == RELEASE &&  owner_d);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         I_READ, D_READ, D_WRITE;
  logic [27:0]  I_ADDRESS, D_ADDRESS;
  logic [127:0] D_WRITEDATA;
  logic [127:0] I_READDATA, D_READDATA;
  logic         I_BUSYWAIT, D_BUSYWAIT;
  logic         M_READ, M_WRITE;
  logic [27:0]  M_ADDRESS;
  logic [127:0] M_WRITEDATA, M_READDATA;
  logic         M_BUSYWAIT;
  logic         ARB_ERROR;

  mem_arbiter #(.ADDR_WIDTH(28), .DATA_WIDTH(128), .TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT), .ARB_ERROR(ARB_ERROR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [27:0] a);
    return {32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 4'h0, a + 28'd3};
  endfunction

  // memory model: busy for mem_lat cycles after the strobe rises, or forever when stuck
  int   mem_cnt = 0;
  int   mem_lat = 4;
  logic mem_stuck = 1'b0;
  always @(posedge CLK) mem_cnt <= (M_READ | M_WRITE) ? mem_cnt + 1 : 0;
  assign M_BUSYWAIT = (M_READ | M_WRITE) && (mem_stuck || mem_cnt < mem_lat);
  assign M_READDATA = blk(M_ADDRESS);

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;
    int           start;
    int           len;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  logic strobe_prev = 1'b0;
  int   high_cnt = 0;

  task automatic push(input logic wr, input logic [27:0] addr, input logic [127:0] data,
                      input int start, input int len);
    txn_t t;
    t.wr = wr; t.addr = addr; t.data = data; t.start = start; t.len = len;
    exp_q.push_back(t);
  endtask

  always @(negedge CLK) begin
    if ((M_READ | M_WRITE) && !strobe_prev) begin
      check("txn_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("grant_cycle", cyc - t0, cur.start);
        check("m_write", M_WRITE, cur.wr);
        check("m_read", M_READ, !cur.wr);
        check("m_address", M_ADDRESS, cur.addr);
        if (cur.wr) check("m_writedata", M_WRITEDATA, cur.data);
      end
      high_cnt = 1;
    end else if (M_READ | M_WRITE) begin
      high_cnt++;
    end else if (strobe_prev && cur.len > 0) begin
      check("strobe_cycles", high_cnt, cur.len);
    end
    strobe_prev = M_READ | M_WRITE;
  end

  task automatic i_txn(input logic [27:0] addr, input logic [127:0] exp_rd, input int rel);
    int n = 0;
    I_ADDRESS = addr;
    I_READ = 1'b1;
    do begin @(negedge CLK); n++; end while (I_BUSYWAIT && n < 60);
    check("i_busywait_low", I_BUSYWAIT, 1'b0);
    check("i_release_cycle", cyc - t0, rel);
    check("i_readdata", I_READDATA, exp_rd);
    @(posedge CLK); #1;
    I_READ = 1'b0;
  endtask

  task automatic d_txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wdata, input logic [127:0] exp_rd, input int rel);
    int n = 0;
    D_ADDRESS = addr;
    D_WRITEDATA = wdata;
    D_READ = rd;
    D_WRITE = wr;
    do begin @(negedge CLK); n++; end while (D_BUSYWAIT && n < 60);
    check("d_busywait_low", D_BUSYWAIT, 1'b0);
    check("d_release_cycle", cyc - t0, rel);
    check("d_readdata", D_READDATA, exp_rd);
    @(posedge CLK); #1;
    D_READ = 1'b0;
    D_WRITE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_m_read", M_READ, 1'b0);
    check("rst_m_write", M_WRITE, 1'b0);
    check("rst_m_address", M_ADDRESS, '0);
    check("rst_i_readdata", I_READDATA, '0);
    check("rst_d_readdata", D_READDATA, '0);
    check("rst_arb_error", ARB_ERROR, 1'b0);
    check("rst_i_busywait", I_BUSYWAIT, 1'b0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    // single I refill, L=4
    t0 = cyc;
    push(1'b0, 28'h0000010, '0, 1, 5);
    i_txn(28'h0000010, blk(28'h0000010), 6);

    // two simultaneous pairs: D wins both ties
    for (int p = 0; p < 2; p++) begin
      t0 = cyc;
      push(1'b0, 28'h0000030, '0, 1, 5);
      push(1'b0, 28'h0000020, '0, 8, 5);
      fork
        d_txn(1'b1, 1'b0, 28'h0000030, '0, blk(28'h0000030), 6);
        i_txn(28'h0000020, blk(28'h0000020), 13);
      join
    end

    // write-back with both D strobes high: write wins, D_READDATA untouched
    t0 = cyc;
    push(1'b1, 28'h0000040, 128'h11112222_33334444_55556666_77778888, 1, 5);
    d_txn(1'b1, 1'b1, 28'h0000040, 128'h11112222_33334444_55556666_77778888,
          blk(28'h0000030), 6);

    // stuck memory: timeout after 8 grant cycles
    check("err_before_timeout", ARB_ERROR, 1'b0);
    mem_stuck = 1'b1;
    t0 = cyc;
    push(1'b0, 28'h0000050, '0, 1, 8);
    i_txn(28'h0000050, blk(28'h0000020), 9);
    mem_stuck = 1'b0;
    check("err_after_timeout", ARB_ERROR, 1'b1);

    t0 = cyc;
    push(1'b0, 28'h0000060, '0, 1, 5);
    d_txn(1'b1, 1'b0, 28'h0000060, '0, blk(28'h0000060), 6);
    check("err_sticky", ARB_ERROR, 1'b1);

    // write-back then refill with an I refill arriving in between
    t0 = cyc;
    push(1'b1, 28'h0000080, 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0, 1, 5);
    push(1'b0, 28'h00000A0, '0, 8, 5);
    push(1'b0, 28'h0000090, '0, 15, 5);
    fork
      begin
        d_txn(1'b0, 1'b1, 28'h0000080, 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0,
              blk(28'h0000060), 6);
        d_txn(1'b1, 1'b0, 28'h0000090, '0, blk(28'h0000090), 20);
      end
      begin
        @(posedge CLK); #1;
        i_txn(28'h00000A0, blk(28'h00000A0), 13);
      end
    join

    // asynchronous reset during GRANT_D cycle 3, then re-grant of the held request
    mem_lat = 6;
    t0 = cyc;
    push(1'b0, 28'h0000070, '0, 1, 0);
    D_ADDRESS = 28'h0000070;
    D_READ = 1'b1;
    repeat (4) @(negedge CLK);
    check("pre_rst_m_read", M_READ, 1'b1);
    RESET = 1'b0;
    #1;
    check("async_m_read", M_READ, 1'b0);
    check("async_m_write", M_WRITE, 1'b0);
    check("async_m_address", M_ADDRESS, '0);
    check("async_m_writedata", M_WRITEDATA, '0);
    check("async_i_readdata", I_READDATA, '0);
    check("async_d_readdata", D_READDATA, '0);
    check("async_arb_error", ARB_ERROR, 1'b0);
    check("async_d_busywait", D_BUSYWAIT, 1'b1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    t0 = cyc;
    push(1'b0, 28'h0000070, '0, 1, 7);
    d_txn(1'b1, 1'b0, 28'h0000070, '0, blk(28'h0000070), 8);
    mem_lat = 4;

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
